tbird_lamp_monitor: RTL and testbench

TBIRD_LAMP_MONITOR -- requirements
Module: tbird_lamp_monitor

---
 rtl/tbird_lamp_monitor.sv | 135 +++++++++++++
 tb/tb_tbird_lamp_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tbird_lamp_monitor.sv
// Watches the six tail-lamp lines of a T-bird turn-signal FSM, tracks its step, counts sequences, flags violations.
// Latency: one cycle; every output is registered and reflects the lamps sampled at the previous rising edge.
// Backpressure: none; the block is a passive observer and samples every cycle.
module tbird_lamp_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             la,
    input  logic             lb,
    input  logic             lc,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    output logic [1:0]       dir,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic             err,
    output logic             err_pulse
);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_L1   = 3'd1,
        S_L2   = 3'd2,
        S_L3   = 3'd3,
        S_R1   = 3'd4,
        S_R2   = 3'd5,
        S_R3   = 3'd6,
        S_SYNC = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    state_t           pat_st;
    logic             legal;
    logic             viol_d;
    logic [1:0]       dir_q, phase_q;
    logic [CNT_W-1:0] left_cnt_q, right_cnt_q;
    logic             err_q, err_pulse_q;

    // Direction code for a state: 01 left, 10 right, 00 otherwise.
    function automatic logic [1:0] dir_of(state_t s);
        case (s)
            S_L1, S_L2, S_L3: dir_of = 2'b01;
            S_R1, S_R2, S_R3: dir_of = 2'b10;
            default:          dir_of = 2'b00;
        endcase
    endfunction

    // Number of lamps lit in a lamp state, 0 for OFF and SYNC.
    function automatic logic [1:0] phase_of(state_t s);
        case (s)
            S_L1, S_R1: phase_of = 2'd1;
            S_L2, S_R2: phase_of = 2'd2;
            S_L3, S_R3: phase_of = 2'd3;
            default:    phase_of = 2'd0;
        endcase
    endfunction

    // Map the sampled lamp pattern to the state it names; anything unnamed maps to SYNC (illegal).
    always_comb begin
        case ({la, lb, lc, ra, rb, rc})
            6'b000000: pat_st = S_OFF;
            6'b100000: pat_st = S_L1;
            6'b110000: pat_st = S_L2;
            6'b111000: pat_st = S_L3;
            6'b000100: pat_st = S_R1;
            6'b000110: pat_st = S_R2;
            6'b000111: pat_st = S_R3;
            default:   pat_st = S_SYNC;
        endcase
    end

    // Judge the pattern against the current state; SYNC waits quietly for OFF before tracking again.
    always_comb begin
        legal   = 1'b0;
        viol_d  = 1'b0;
        state_d = state_q;
        case (state_q)
            S_OFF:   legal = (pat_st == S_OFF) || (pat_st == S_L1) || (pat_st == S_R1);
            S_L1:    legal = (pat_st == S_L2);
            S_L2:    legal = (pat_st == S_L3);
            S_R1:    legal = (pat_st == S_R2);
            S_R2:    legal = (pat_st == S_R3);
            S_L3,
            S_R3:    legal = (pat_st == S_OFF);
            default: legal = 1'b0;
        endcase
        if (state_q == S_SYNC) begin
            state_d = (pat_st == S_OFF) ? S_OFF : S_SYNC;
        end else if (legal) begin
            state_d = pat_st;
        end else begin
            state_d = S_SYNC;
            viol_d  = 1'b1;
        end
    end

    // State, decoded outputs, saturating sequence counters and error flags, all updated together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_OFF;
            dir_q       <= 2'b00;
            phase_q     <= 2'd0;
            left_cnt_q  <= '0;
            right_cnt_q <= '0;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_of(state_d);
            phase_q     <= phase_of(state_d);
            err_q       <= err_q | viol_d;
            err_pulse_q <= viol_d;
            if (state_q == S_L3 && state_d == S_OFF && left_cnt_q != CNT_MAX) begin
                left_cnt_q <= left_cnt_q + CNT_ONE;
            end
            if (state_q == S_R3 && state_d == S_OFF && right_cnt_q != CNT_MAX) begin
                right_cnt_q <= right_cnt_q + CNT_ONE;
            end
        end
    end

    assign dir       = dir_q;
    assign phase     = phase_q;
    assign left_cnt  = left_cnt_q;
    assign right_cnt = right_cnt_q;
    assign err       = err_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_tbird_lamp_monitor.sv
// Bench for tbird_lamp_monitor: two instances (8-bit and 2-bit counters) share one lamp stimulus.
// Latency: expected values are checked 1 time unit after the edge that samples each vector.
// Backpressure: none; one vector is applied per clock.
module tb_tbird_lamp_monitor;

    localparam logic [5:0] P_OFF = 6'b000000;
    localparam logic [5:0] P_L1  = 6'b100000;
    localparam logic [5:0] P_L2  = 6'b110000;
    localparam logic [5:0] P_L3  = 6'b111000;
    localparam logic [5:0] P_R1  = 6'b000100;
    localparam logic [5:0] P_R2  = 6'b000110;
    localparam logic [5:0] P_R3  = 6'b000111;

    typedef struct packed {
        logic       rst;
        logic [5:0] pat;
        logic [1:0] dir;
        logic [1:0] phase;
        logic [7:0] lcnt;
        logic [7:0] rcnt;
        logic       err;
        logic       pulse;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic la = 1'b0, lb = 1'b0, lc = 1'b0, ra = 1'b0, rb = 1'b0, rc = 1'b0;

    logic [1:0] dir, phase;
    logic [7:0] left_cnt, right_cnt;
    logic       err, err_pulse;
    logic [1:0] s_dir, s_phase;
    logic [1:0] s_left_cnt, s_right_cnt;
    logic       s_err, s_err_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    tbird_lamp_monitor #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
        .dir(dir), .phase(phase), .left_cnt(left_cnt), .right_cnt(right_cnt),
        .err(err), .err_pulse(err_pulse)
    );

    tbird_lamp_monitor #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
        .dir(s_dir), .phase(s_phase), .left_cnt(s_left_cnt), .right_cnt(s_right_cnt),
        .err(s_err), .err_pulse(s_err_pulse)
    );

    task automatic add(input logic r, input logic [5:0] p, input logic [1:0] d, input logic [1:0] ph,
                       input int lcn, input int rcn, input logic e, input logic pu);
        vec_t v;
        v.rst = r; v.pat = p; v.dir = d; v.phase = ph;
        v.lcnt = 8'(lcn); v.rcnt = 8'(rcn); v.err = e; v.pulse = pu;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic logic [7:0] sat2(input logic [7:0] v);
        return (v > 8'd3) ? 8'd3 : v;
    endfunction

    initial begin
        vec_t v, e;

        // Reset state, with an illegal both-sides pattern on the lamps that must be ignored.
        add(1, 6'b111111, 0, 0, 0, 0, 0, 0);

        // Full left cycle.
        add(0, P_OFF, 0, 0, 0, 0, 0, 0);
        add(0, P_L1,  1, 1, 0, 0, 0, 0);
        add(0, P_L2,  1, 2, 0, 0, 0, 0);
        add(0, P_L3,  1, 3, 0, 0, 0, 0);
        add(0, P_OFF, 0, 0, 1, 0, 0, 0);

        // Mixed traffic: three right cycles, then two left cycles separated by OFF.
        add(1, P_OFF, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            add(0, P_R1,  2, 1, 0, c, 0, 0);
            add(0, P_R2,  2, 2, 0, c, 0, 0);
            add(0, P_R3,  2, 3, 0, c, 0, 0);
            add(0, P_OFF, 0, 0, 0, c + 1, 0, 0);
        end
        for (int c = 0; c < 2; c++) begin
            add(0, P_L1,  1, 1, c, 3, 0, 0);
            add(0, P_L2,  1, 2, c, 3, 0, 0);
            add(0, P_L3,  1, 3, c, 3, 0, 0);
            add(0, P_OFF, 0, 0, c + 1, 3, 0, 0);
            add(0, P_OFF, 0, 0, c + 1, 3, 0, 0);
        end

        // Skipped step, held illegal pattern, then resync into a right sequence.
        add(1, P_OFF, 0, 0, 0, 0, 0, 0);
        add(0, P_OFF, 0, 0, 0, 0, 0, 0);
        add(0, P_L1,  1, 1, 0, 0, 0, 0);
        add(0, P_L3,  0, 0, 0, 0, 1, 1);
        add(0, P_L3,  0, 0, 0, 0, 1, 0);
        add(0, P_L3,  0, 0, 0, 0, 1, 0);
        add(0, P_OFF, 0, 0, 0, 0, 1, 0);
        add(0, P_R1,  2, 1, 0, 0, 1, 0);

        // Illegal both-sides pattern from OFF; later a direct L3 -> R1 step while err is already set.
        add(1, P_OFF,     0, 0, 0, 0, 0, 0);
        add(0, 6'b100100, 0, 0, 0, 0, 1, 1);
        add(0, P_OFF,     0, 0, 0, 0, 1, 0);
        add(0, P_L1,      1, 1, 0, 0, 1, 0);
        add(0, P_L2,      1, 2, 0, 0, 1, 0);
        add(0, P_L3,      1, 3, 0, 0, 1, 0);
        add(0, P_R1,      0, 0, 0, 0, 1, 1);
        add(0, P_R1,      0, 0, 0, 0, 1, 0);
        add(0, P_OFF,     0, 0, 0, 0, 1, 0);
        add(0, P_OFF,     0, 0, 0, 0, 1, 0);

        // OFF held indefinitely is quiet; then five left cycles (small instance saturates at 3).
        add(1, P_OFF, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, P_OFF, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            add(0, P_L1,  1, 1, c, 0, 0, 0);
            add(0, P_L2,  1, 2, c, 0, 0, 0);
            add(0, P_L3,  1, 3, c, 0, 0, 0);
            add(0, P_OFF, 0, 0, c + 1, 0, 0, 0);
        end

        // Reset mid-sequence aborts without counting; tracking restarts from OFF.
        add(1, P_OFF, 0, 0, 0, 0, 0, 0);
        add(0, P_OFF, 0, 0, 0, 0, 0, 0);
        add(0, P_L1,  1, 1, 0, 0, 0, 0);
        add(0, P_L2,  1, 2, 0, 0, 0, 0);
        add(1, P_L3,  0, 0, 0, 0, 0, 0);
        add(0, P_OFF, 0, 0, 0, 0, 0, 0);
        add(0, P_L1,  1, 1, 0, 0, 0, 0);

        // Apply each vector, queue its expectation, compare after the sampling edge.
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            reset = v.rst;
            {la, lb, lc, ra, rb, rc} = v.pat;
            sb.push_back(v);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard vec %0d: got empty queue, expected one entry", i);
            end else begin
                e = sb.pop_front();
                chk("dir",         i, {6'b0, dir},         {6'b0, e.dir});
                chk("phase",       i, {6'b0, phase},       {6'b0, e.phase});
                chk("left_cnt",    i, left_cnt,            e.lcnt);
                chk("right_cnt",   i, right_cnt,           e.rcnt);
                chk("err",         i, {7'b0, err},         {7'b0, e.err});
                chk("err_pulse",   i, {7'b0, err_pulse},   {7'b0, e.pulse});
                chk("s_dir",       i, {6'b0, s_dir},       {6'b0, e.dir});
                chk("s_phase",     i, {6'b0, s_phase},     {6'b0, e.phase});
                chk("s_left_cnt",  i, {6'b0, s_left_cnt},  sat2(e.lcnt));
                chk("s_right_cnt", i, {6'b0, s_right_cnt}, sat2(e.rcnt));
                chk("s_err",       i, {7'b0, s_err},       {7'b0, e.err});
                chk("s_err_pulse", i, {7'b0, s_err_pulse}, {7'b0, e.pulse});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
